keypad_matrix_scanner: RTL and testbench

- Front end feeding the microwave's `keypad[9:0]` input from a physical 4x3 matrix keypad.
- Drives rows low one at a time and samples the active-low columns through a 2-flop synchronizer.
- Debounces and encodes the result into a one-hot digit level, plus `*`/`#` levels and a one-cycle strobe per accepted press.
- Sits between the board pins and the time-entry/control block.

---
 rtl/keypad_matrix_scanner_pkg.sv | 30 +++
 rtl/keypad_snapshot_encoder.sv | 24 ++
 rtl/keypad_matrix_scanner.sv | 167 ++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared definitions for the keypad matrix scanner: code constants, FSM states
// and the physical (row, column) to key-code map.
package keypad_matrix_scanner_pkg;

    localparam logic [3:0] KEY_NONE  = 4'hF;
    localparam logic [3:0] KEY_MULTI = 4'hE;
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_HASH  = 4'd11;

    typedef enum logic {
        StIdle    = 1'b0,
        StPressed = 1'b1
    } kp_state_e;

    // Key code at a matrix position: r0..r2 carry digits 1..9, r3 carries *,0,#.
    function automatic logic [3:0] key_at(logic [1:0] row, logic [1:0] col);
        logic [3:0] code;
        if (row != 2'd3) begin
            code = 4'(row) * 4'd3 + 4'(col) + 4'd1;
        end else begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_snapshot_encoder.sv
// Combinational encoder: 12-bit key snapshot (bit index = key code) to a
// 4-bit code: KEY_NONE when empty, KEY_MULTI when more than one key, else index.
module keypad_snapshot_encoder
    import keypad_matrix_scanner_pkg::*;
(
    input  logic [11:0] snap_i,
    output logic [3:0]  code_o
);

    // First set bit yields its index, any further set bit collapses to KEY_MULTI.
    always_comb begin
        code_o = KEY_NONE;
        for (int i = 0; i < 12; i++) begin
            if (snap_i[i]) begin
                if (code_o == KEY_NONE) begin
                    code_o = 4'(i);
                end else begin
                    code_o = KEY_MULTI;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x3 matrix keypad scanner with synchronizer, full-scan debounce, rollover
// lockout and one-hot digit / star / hash level outputs plus a press strobe.
// Optional auto-repeat of digit strobes is enabled by KEYPAD_AUTOREPEAT_EN.
module keypad_matrix_scanner
    import keypad_matrix_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 8,
    parameter int unsigned DEBOUNCE_SCANS = 3,
    parameter int unsigned REPEAT_SCANS   = 50
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] col_n,
    output logic [3:0] row_n,
    output logic [9:0] keypad,
    output logic       key_star,
    output logic       key_hash,
    output logic       key_strobe
);

    localparam int unsigned     DivW      = $clog2(SCAN_DIV);
    localparam logic [DivW-1:0] DivLast   = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]      DebTarget = 4'(DEBOUNCE_SCANS);

    logic [2:0]      col_s1_q, col_s2_q;
    logic [DivW-1:0] div_cnt_q;
    logic [1:0]      row_idx_q;
    logic [11:0]     snap_q, snap_d;
    logic [3:0]      code;
    logic [3:0]      prev_code_q;
    logic [3:0]      stable_cnt_q, stable_d;
    logic            sample, scan_end;
    kp_state_e       state_q;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_SCANS + 1);
    logic [RepW-1:0] repeat_cnt_q;
`endif

    assign sample   = (div_cnt_q == DivLast);
    assign scan_end = sample && (row_idx_q == 2'd3);
    assign row_n    = ~(4'b0001 << row_idx_q);

    // Two-flop synchronizer on the asynchronous column inputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_s1_q <= 3'b111;
            col_s2_q <= 3'b111;
        end else begin
            col_s1_q <= col_n;
            col_s2_q <= col_s1_q;
        end
    end

    // Row dwell counter and row selector.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt_q <= '0;
            row_idx_q <= 2'd0;
        end else if (sample) begin
            div_cnt_q <= '0;
            row_idx_q <= row_idx_q + 2'd1;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    // Merge the current row's columns into the snapshot on its last dwell clock.
    always_comb begin
        snap_d = snap_q;
        if (sample) begin
            for (int c = 0; c < 3; c++) begin
                snap_d[key_at(row_idx_q, 2'(c))] = ~col_s2_q[c];
            end
        end
    end

    // Snapshot register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    // Encoder sees the completed snapshot, including the row sampled this cycle.
    keypad_snapshot_encoder u_encoder (
        .snap_i (snap_d),
        .code_o (code)
    );

    // Consecutive-identical-scan counter, saturating at the debounce target.
    always_comb begin
        if (code != prev_code_q) begin
            stable_d = 4'd1;
        end else if (stable_cnt_q >= DebTarget) begin
            stable_d = DebTarget;
        end else begin
            stable_d = stable_cnt_q + 4'd1;
        end
    end

    // Debounce history updated once per full scan.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_code_q  <= KEY_NONE;
            stable_cnt_q <= 4'd0;
        end else if (scan_end) begin
            prev_code_q  <= code;
            stable_cnt_q <= stable_d;
        end
    end

    // Accept / release FSM with registered level and strobe outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            keypad     <= '0;
            key_star   <= 1'b0;
            key_hash   <= 1'b0;
            key_strobe <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            repeat_cnt_q <= '0;
`endif
        end else begin
            key_strobe <= 1'b0;
            if (scan_end) begin
                case (state_q)
                    StIdle: begin
                        if (code <= KEY_HASH && stable_d == DebTarget) begin
                            state_q    <= StPressed;
                            keypad     <= (code < 4'd10) ? (10'd1 << code) : 10'd0;
                            key_star   <= (code == KEY_STAR);
                            key_hash   <= (code == KEY_HASH);
                            key_strobe <= 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            repeat_cnt_q <= '0;
`endif
                        end
                    end
                    StPressed: begin
                        // Other keys or multi-key codes are locked out until full release.
                        if (code == KEY_NONE && stable_d == DebTarget) begin
                            state_q  <= StIdle;
                            keypad   <= '0;
                            key_star <= 1'b0;
                            key_hash <= 1'b0;
                        end
`ifdef KEYPAD_AUTOREPEAT_EN
                        else if (keypad != 10'd0) begin
                            if (repeat_cnt_q == RepW'(REPEAT_SCANS - 1)) begin
                                key_strobe   <= 1'b1;
                                repeat_cnt_q <= '0;
                            end else begin
                                repeat_cnt_q <= repeat_cnt_q + 1'b1;
                            end
                        end
`endif
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner: a behavioural keypad and a
// scan-level reference model predict every output event; a monitor compares.
module tb_keypad_matrix_scanner;

    localparam int SD  = 4;
    localparam int DEB = 3;
    localparam int REP = 5;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif
    // Key code at matrix position r*3+c.
    localparam int KM [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

    logic       clk;
    logic       rstn;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       key_star;
    logic       key_hash;
    logic       key_strobe;

    logic [11:0] keys_down;

    int n_checks;
    int n_fail;
    int edge_n;

    typedef struct {
        int          cyc;
        logic        strobe;
        logic [11:0] lv;
    } ev_t;
    ev_t exp_q[$];

    keypad_matrix_scanner #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB),
        .REPEAT_SCANS   (REP)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .col_n      (col_n),
        .row_n      (row_n),
        .keypad     (keypad),
        .key_star   (key_star),
        .key_hash   (key_hash),
        .key_strobe (key_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!row_n[r] && keys_down[KM[r*3+c]]) col_n[c] = 1'b0;
            end
        end
    end

    // Reference model: per clock edge, decide which key state the scanner sees,
    // and at each full scan apply the accept/release rules.
    initial begin
        logic [11:0] h1, h2, snap, lv;
        int prev_code, stable, held, rep, cnt, code, phase, r, n;
        bit pressed, strobe, changed;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                h1 = '0; h2 = '0; snap = '0;
                prev_code = 15; stable = 0; pressed = 0; held = 0; rep = 0;
                exp_q.delete();
                edge_n = -1;
                continue;
            end
            n = edge_n + 1;
            phase = n % (4 * SD);
            if (phase % SD == SD - 1) begin
                r = phase / SD;
                for (int c = 0; c < 3; c++) snap[KM[r*3+c]] = h2[KM[r*3+c]];
                if (r == 3) begin
                    cnt = $countones(snap);
                    code = 15;
                    if (cnt > 1) code = 14;
                    else if (cnt == 1) begin
                        for (int k = 0; k < 12; k++) if (snap[k]) code = k;
                    end
                    if (code == prev_code) stable = (stable + 1 > DEB) ? DEB : stable + 1;
                    else stable = 1;
                    prev_code = code;
                    strobe = 0;
                    changed = 0;
                    if (!pressed) begin
                        if (code < 12 && stable == DEB) begin
                            pressed = 1; held = code; rep = 0; strobe = 1;
                        end
                    end else if (code == 15 && stable == DEB) begin
                        pressed = 0; changed = 1;
                    end else if (REP_EN && held < 10) begin
                        rep++;
                        if (rep == REP) begin strobe = 1; rep = 0; end
                    end
                    if (strobe || changed) begin
                        lv = pressed ? (12'd1 << held) : 12'd0;
                        exp_q.push_back('{cyc: n, strobe: strobe, lv: lv});
                    end
                end
            end
            h2 = h1;
            h1 = keys_down;
            edge_n = n;
        end
    end

    // Monitor: compares every DUT output event with the next predicted one.
    initial begin
        logic [11:0] last_lv, dut_lv;
        logic [3:0]  exp_row;
        logic        prev_strobe;
        ev_t e;
        last_lv = '0;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                last_lv = '0;
                prev_strobe = 1'b0;
                continue;
            end
            dut_lv = {key_hash, key_star, keypad};
            exp_row = ~(4'b0001 << (((edge_n + 1) / SD) % 4));
            n_checks++;
            if (row_n !== exp_row) begin
                n_fail++;
                $display("FAIL row_n cyc=%0d actual=%b required=%b", edge_n, row_n, exp_row);
            end
            n_checks++;
            if ($countones(dut_lv) > 1 || (prev_strobe && key_strobe)) begin
                n_fail++;
                $display("FAIL invariant cyc=%0d levels=%b strobe=%b prev_strobe=%b",
                         edge_n, dut_lv, key_strobe, prev_strobe);
            end
            if (key_strobe || dut_lv !== last_lv) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event cyc=%0d actual levels=%b strobe=%b required none",
                             edge_n, dut_lv, key_strobe);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != edge_n || e.strobe !== key_strobe || e.lv !== dut_lv) begin
                        n_fail++;
                        $display("FAIL event actual cyc=%0d lv=%b stb=%b required cyc=%0d lv=%b stb=%b",
                                 edge_n, dut_lv, key_strobe, e.cyc, e.lv, e.strobe);
                    end
                end
                last_lv = dut_lv;
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
                n_checks++;
                n_fail++;
                e = exp_q.pop_front();
                $display("FAIL missed_event cyc=%0d actual lv=%b stb=%b required lv=%b stb=%b",
                         edge_n, dut_lv, key_strobe, e.lv, e.strobe);
            end
            prev_strobe = key_strobe;
        end
    end

    task automatic hold(input int clks);
        repeat (clks) @(negedge clk);
    endtask

    task automatic check_lv(input string name, input logic [11:0] req);
        logic [11:0] act;
        act = {key_hash, key_star, keypad};
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] keys;
        int sel;
        n_checks = 0;
        n_fail = 0;
        keys_down = '0;
        rstn = 1'b0;
        #1;
        n_checks++;
        if (row_n !== 4'b1110 || keypad !== 10'd0 || key_star || key_hash || key_strobe) begin
            n_fail++;
            $display("FAIL reset_state actual row=%b kp=%b st=%b hs=%b sb=%b required 1110/0/0/0/0",
                     row_n, keypad, key_star, key_hash, key_strobe);
        end
        hold(3);
        rstn = 1'b1;

        // Idle: ten scans with nothing pressed.
        hold(10 * 16);
        check_lv("idle_levels", 12'd0);

        // Key 5 held steady, then released.
        keys_down = 12'd1 << 5;
        hold(6 * 16);
        check_lv("key5_held", 12'd1 << 5);
        keys_down = '0;
        hold(5 * 16);
        check_lv("key5_released", 12'd0);

        // Key 7 bouncing every 5 clocks for two scans, then steady.
        for (int i = 0; i < 7; i++) begin
            keys_down = keys_down ^ (12'd1 << 7);
            hold(5);
        end
        keys_down = 12'd1 << 7;
        hold(5 * 16);
        check_lv("key7_after_bounce", 12'd1 << 7);
        keys_down = '0;
        hold(5 * 16);

        // Keys 2 and 9 together, then 9 released with 2 held.
        keys_down = (12'd1 << 2) | (12'd1 << 9);
        hold(5 * 16);
        check_lv("multi_2_9", 12'd0);
        keys_down = 12'd1 << 2;
        hold(5 * 16);
        check_lv("key2_after_multi", 12'd1 << 2);
        keys_down = '0;
        hold(5 * 16);

        // Rollover lockout: 0 held, # added, 0 released with # held.
        keys_down = 12'd1 << 0;
        hold(5 * 16);
        keys_down = (12'd1 << 0) | (12'd1 << 11);
        hold(4 * 16);
        keys_down = 12'd1 << 11;
        hold(5 * 16);
        check_lv("hash_locked_out", 12'd1 << 0);
        keys_down = '0;
        hold(5 * 16);
        check_lv("full_release", 12'd0);
        keys_down = 12'd1 << 11;
        hold(5 * 16);
        check_lv("hash_fresh_press", 12'd1 << 11);
        keys_down = '0;
        hold(5 * 16);

        // Asynchronous reset while key 3 is accepted.
        keys_down = 12'd1 << 3;
        hold(5 * 16 + 5);
        check_lv("key3_held", 12'd1 << 3);
        #2 rstn = 1'b0;
        #1;
        check_lv("async_reset_levels", 12'd0);
        n_checks++;
        if (row_n !== 4'b1110 || key_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_row actual row=%b sb=%b required 1110/0", row_n, key_strobe);
        end
        hold(2);
        rstn = 1'b1;
        hold(12 * 16);
        keys_down = '0;
        hold(5 * 16);

        // Randomized presses, multi-key chords, gaps and bounces.
        for (int it = 0; it < 40; it++) begin
            sel = $urandom_range(0, 99);
            if (sel < 65) keys = 12'd1 << $urandom_range(0, 11);
            else if (sel < 85) keys = (12'd1 << $urandom_range(0, 11)) | (12'd1 << $urandom_range(0, 11));
            else keys = '0;
            if ($urandom_range(0, 3) == 0) begin
                for (int b = 0; b < int'($urandom_range(2, 6)); b++) begin
                    keys_down = keys_down ^ keys;
                    hold($urandom_range(1, 7));
                end
            end
            keys_down = keys;
            hold($urandom_range(1, 8) * 16 + $urandom_range(0, 15));
        end
        keys_down = '0;
        hold(6 * 16);
        check_lv("final_release", 12'd0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events actual=%0d required=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
